sub32_serial: RTL and testbench



---
 rtl/sub32_serial_pkg.sv | 22 ++
 rtl/sub32_serial_sub4_slice.sv | 21 ++
 rtl/sub32_serial.sv | 125 ++++++++++++
 tb/tb_sub32_serial.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sub32_serial_pkg.sv
// ---------------------------------------------------------------------------
// sub32_serial_pkg : shared constants and state encoding for sub32_serial
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sub32_serial_pkg;

    localparam int WIDTH  = 32;
    localparam int SLICE  = 4;
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = $clog2(NSLICE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sub32_serial_sub4_slice.sv
// ---------------------------------------------------------------------------
// sub4_slice : combinational 4-bit a + ~b + ci slice (ci is an active-high carry)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sub4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    always_comb begin
        {co, s} = {1'b0, a} + {1'b0, ~b} + {4'd0, ci};
    end

endmodule

`default_nettype wire

// File: rtl/sub32_serial.sv
// ---------------------------------------------------------------------------
// sub32_serial : 32-bit subtractor computing a - b - bi one 4-bit slice per clock
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sub32_serial
    import sub32_serial_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             ovf,
    output logic             zero
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               bo_q, bo_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    logic [SLICE-1:0]   slice_s;
    logic               slice_co;

    // Operands shift right each RUN cycle, so the active slice is always the low nibble.
    sub4_slice u_slice (
        .a  (a_q[SLICE-1:0]),
        .b  (b_q[SLICE-1:0]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        d_d     = d_q;
        bo_d    = bo_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = ~bi;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> SLICE;
                b_d     = b_q >> SLICE;
                res_d   = {slice_s, res_q[WIDTH-1:SLICE]};
                carry_d = slice_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NSLICE - 1)) begin
                    // Low nibble of the shifted operands now holds the original sign bits.
                    state_d = DONE;
                    d_d     = res_d;
                    bo_d    = ~slice_co;
                    ovf_d   = (a_q[SLICE-1] != b_q[SLICE-1]) && (slice_s[SLICE-1] != a_q[SLICE-1]);
                    zero_d  = (res_d == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            d_q     <= '0;
            bo_q    <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            d_q     <= d_d;
            bo_q    <= bo_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign d    = d_q;
    assign bo   = bo_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_sub32_serial.sv
// ---------------------------------------------------------------------------
// tb_sub32_serial : directed self-checking bench for sub32_serial
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sub32_serial;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        bi;
    logic        busy;
    logic        done;
    logic [31:0] d;
    logic        bo;
    logic        ovf;
    logic        zero;

    int n_checks;
    int n_fail;

    sub32_serial dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .bi      (bi),
        .busy    (busy),
        .done    (done),
        .d       (d),
        .bo      (bo),
        .ovf     (ovf),
        .zero    (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a one-cycle start pulse; returns at the negedge just after the accept edge.
    task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic biv);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        bi    = biv;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count negedges until done is seen (bounded).
    task automatic wait_done(output int n, output bit timeout);
        n = 0;
        timeout = 1'b0;
        while (!done) begin
            @(negedge clk);
            n++;
            if (n >= 30) begin
                timeout = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        bi      = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, d, bo, ovf, zero} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b d=%h bo=%b ovf=%b zero=%b, need all 0",
                     busy, done, d, bo, ovf, zero);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        logic [31:0] va  [6] = '{32'd5, 32'd0, 32'h12345678, 32'h80000000, 32'h7FFFFFFF, 32'd0};
        logic [31:0] vb  [6] = '{32'd3, 32'd1, 32'h12345677, 32'h00000001, 32'hFFFFFFFF, 32'd0};
        logic        vbi [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] ed  [6] = '{32'h2, 32'hFFFFFFFF, 32'h0, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        logic        ebo [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        eov [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        ez  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        int n;
        bit to;
        for (int i = 0; i < 6; i++) begin
            start_op(va[i], vb[i], vbi[i]);
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL vec%0d_busy: got %b, need 1", i, busy);
            end
            wait_done(n, to);
            n_checks++;
            if (to || n != 8) begin
                n_fail++;
                $display("FAIL vec%0d_latency: got %0d edges (timeout=%0d), need 8", i, n, to);
            end
            n_checks++;
            if ({d, bo, ovf, zero, busy} !== {ed[i], ebo[i], eov[i], ez[i], 1'b0}) begin
                n_fail++;
                $display("FAIL vec%0d_result: got d=%h bo=%b ovf=%b zero=%b busy=%b, need d=%h bo=%b ovf=%b zero=%b busy=0",
                         i, d, bo, ovf, zero, busy, ed[i], ebo[i], eov[i], ez[i]);
            end
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || d !== ed[i]) begin
                n_fail++;
                $display("FAIL vec%0d_hold: got done=%b d=%h, need done=0 d=%h", i, done, d, ed[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int n;
        int pulses;
        bit to;
        start_op(32'd100, 32'd1, 1'b0);
        repeat (2) @(negedge clk);
        start = 1'b1;
        a     = 32'd7;
        b     = 32'd9;
        bi    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = 32'hDEADBEEF;
        b     = 32'h0BADF00D;
        wait_done(n, to);
        n_checks++;
        if (to || d !== 32'd99 || bo !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_result: got d=%h bo=%b timeout=%0d, need d=00000063 bo=0", d, bo, to);
        end
        pulses = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        n_checks++;
        if (pulses != 1 || d !== 32'd99) begin
            n_fail++;
            $display("FAIL ignore_single_done: got %0d pulses d=%h, need 1 pulse d=00000063", pulses, d);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bit to;
        bit held_ok;
        start_op(32'd20, 32'd5, 1'b0);
        wait_done(n, to);
        n_checks++;
        if (to || d !== 32'd15) begin
            n_fail++;
            $display("FAIL b2b_first: got d=%h timeout=%0d, need d=0000000f", d, to);
        end
        start = 1'b1;
        a     = 32'd10;
        b     = 32'd4;
        bi    = 1'b0;
        n = 0;
        held_ok = 1'b1;
        to = 1'b0;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
            if (!done && d !== 32'd15) held_ok = 1'b0;
            if (n >= 30) to = 1'b1;
        end while (!done && !to);
        n_checks++;
        if (to || n != 9) begin
            n_fail++;
            $display("FAIL b2b_latency: got %0d cycles (timeout=%0d), need 9", n, to);
        end
        n_checks++;
        if (!held_ok || d !== 32'd6) begin
            n_fail++;
            $display("FAIL b2b_result: got d=%h held_ok=%0d, need d=00000006 held_ok=1", d, held_ok);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n;
        int pulses;
        bit to;
        start_op(32'hFFFF0000, 32'h00000123, 1'b0);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, d, bo, ovf, zero} !== 36'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got busy=%b done=%b d=%h bo=%b ovf=%b zero=%b, need all 0",
                     busy, done, d, bo, ovf, zero);
        end
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        n_checks++;
        if (pulses != 0 || d !== 32'd0) begin
            n_fail++;
            $display("FAIL midreset_no_done: got %0d active cycles d=%h, need 0 and d=00000000", pulses, d);
        end
        start_op(32'd9, 32'd2, 1'b0);
        wait_done(n, to);
        n_checks++;
        if (to || n != 8 || d !== 32'd7 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_fresh: got d=%h n=%0d zero=%b timeout=%0d, need d=00000007 n=8 zero=0",
                     d, n, zero, to);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_vectors();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
